// File: rtl/pll_clock_manager.sv
// Supervisory controller for the iCE40 PLL: sequences PLL reset and lock acquisition,
// qualifies lock stability, retries on loss, falls back to bypass, and drives clock enables.
module pll_clock_manager #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 1024,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int MAX_RETRIES        = 3,
    parameter int NUM_CE             = 2,
    parameter int DIV_WIDTH          = 8
) (
    input  logic                                 clk,
    input  logic                                 RESET,
    input  logic                                 pll_lock,
    input  logic                                 relock_req,
    input  logic [NUM_CE*DIV_WIDTH-1:0]          ce_div,
    output logic                                 pll_resetb,
    output logic                                 pll_bypass,
    output logic                                 sys_reset_n,
    output logic                                 locked,
    output logic                                 fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count,
    output logic [NUM_CE-1:0]                    ce,
    output logic [2:0]                           dbg_state
);

    // Handshake: relock_req is a one-cycle request with no ready; it is acted on only
    // in RUN or BYPASS and silently dropped in every other state.

    localparam int RW    = $clog2(MAX_RETRIES + 1);
    localparam int T_MAX = (LOCK_TIMEOUT > PLL_RST_CYCLES) ?
                           ((LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES) :
                           ((PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES);
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] RST_LAST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4,
        BYPASS    = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [RW-1:0] retry_next, retry_inc;
    logic          lock_meta, lock_s;

    // Two-flop synchroniser; lock_meta must never feed any other logic.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    assign retry_inc = (retry_count == RETRY_MAX) ? retry_count : retry_count + RW'(1);

    always_comb begin
        state_next = state;
        timer_next = timer;
        retry_next = retry_count;
        case (state)
            PLL_RST: begin
                if (timer == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = STABLE;
                    timer_next = '0;
                end else if (timer == TO_LAST) begin
                    state_next = FAIL;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = FAIL;
                    timer_next = '0;
                end else if (timer == STB_LAST) begin
                    state_next = RUN;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            RUN: begin
                // Lock loss takes priority over a coincident relock request.
                if (!lock_s) begin
                    state_next = FAIL;
                end else if (relock_req) begin
                    state_next = PLL_RST;
                    retry_next = '0;
                end
                timer_next = '0;
            end
            FAIL: begin
                retry_next = retry_inc;
                timer_next = '0;
                state_next = (retry_inc == RETRY_MAX) ? BYPASS : PLL_RST;
            end
            BYPASS: begin
                if (relock_req) begin
                    state_next = PLL_RST;
                    retry_next = '0;
                end
                timer_next = '0;
            end
            default: begin
                state_next = PLL_RST;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state       <= PLL_RST;
            timer       <= '0;
            retry_count <= '0;
            sys_reset_n <= 1'b0;
            locked      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            retry_count <= retry_next;
            sys_reset_n <= (state == RUN) || (state == BYPASS);
            locked      <= (state == RUN);
            fault       <= (state == BYPASS);
        end
    end

    assign pll_resetb = (state != PLL_RST);
    assign pll_bypass = (state == BYPASS);
    assign dbg_state  = state;

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        logic [DIV_WIDTH-1:0] cnt;
        logic [DIV_WIDTH-1:0] div;
        logic [DIV_WIDTH-1:0] last;

        assign div  = ce_div[i*DIV_WIDTH +: DIV_WIDTH];
        // A zero divisor is treated as one, so last is 0 for both.
        assign last = (div == '0) ? '0 : div - DIV_WIDTH'(1);

        always_ff @(posedge clk or negedge RESET) begin
            if (!RESET) begin
                cnt   <= '0;
                ce[i] <= 1'b0;
            end else if (!sys_reset_n) begin
                cnt   <= '0;
                ce[i] <= 1'b0;
            end else if (cnt >= last) begin
                cnt   <= '0;
                ce[i] <= 1'b1;
            end else begin
                cnt   <= cnt + DIV_WIDTH'(1);
                ce[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_clock_manager.sv
// Randomised bench for pll_clock_manager: a cycle-level behavioural model predicts
// every output each cycle; a monitor compares the DUT against the expected queue.
module tb_pll_clock_manager;

    localparam int PLL_RST_CYCLES     = 16;
    localparam int LOCK_TIMEOUT       = 1024;
    localparam int LOCK_STABLE_CYCLES = 64;
    localparam int MAX_RETRIES        = 3;

    localparam int PH_RST = 0, PH_WAIT = 1, PH_STB = 2, PH_RUN = 3, PH_FAIL = 4, PH_BYP = 5;

    logic        clk = 1'b0;
    logic        RESET;
    logic        pll_lock;
    logic        relock_req;
    logic [15:0] ce_div;
    logic        pll_resetb, pll_bypass, sys_reset_n, locked, fault;
    logic [1:0]  retry_count;
    logic [1:0]  ce;
    logic [2:0]  dbg_state;

    pll_clock_manager dut (
        .clk         (clk),
        .RESET       (RESET),
        .pll_lock    (pll_lock),
        .relock_req  (relock_req),
        .ce_div      (ce_div),
        .pll_resetb  (pll_resetb),
        .pll_bypass  (pll_bypass),
        .sys_reset_n (sys_reset_n),
        .locked      (locked),
        .fault       (fault),
        .retry_count (retry_count),
        .ce          (ce),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];

    // Behavioural model: phase plus a countdown of remaining cycles in that phase.
    int  ph, rem, retries;
    bit  m_sys, m_locked, m_fault;
    int  m_cnt[2];
    bit  m_ce[2];
    bit  lock_line[$];
    bit  cur_lock;
    logic [15:0] cur_div;

    function automatic void model_reset();
        ph = PH_RST; rem = PLL_RST_CYCLES; retries = 0;
        m_sys = 0; m_locked = 0; m_fault = 0;
        for (int ch = 0; ch < 2; ch++) begin m_cnt[ch] = 0; m_ce[ch] = 0; end
        lock_line.delete();
        lock_line.push_back(1'b0);
        lock_line.push_back(1'b0);
    endfunction

    function automatic logic [8:0] model_out();
        logic [8:0] v;
        v = {ph != PH_RST, ph == PH_BYP, m_sys, m_locked, m_fault, 2'(retries), m_ce[1], m_ce[0]};
        return v;
    endfunction

    function automatic void model_edge(bit lk, bit rl, logic [15:0] dv);
        bit ls;
        int old_ph;
        bit old_sys;
        int d;
        ls = lock_line.pop_front();
        lock_line.push_back(lk);
        old_ph  = ph;
        old_sys = m_sys;
        m_sys    = (old_ph == PH_RUN) || (old_ph == PH_BYP);
        m_locked = (old_ph == PH_RUN);
        m_fault  = (old_ph == PH_BYP);
        for (int ch = 0; ch < 2; ch++) begin
            d = int'(dv[ch*8 +: 8]);
            if (d == 0) d = 1;
            if (!old_sys) begin m_cnt[ch] = 0; m_ce[ch] = 0; end
            else if (m_cnt[ch] >= d - 1) begin m_ce[ch] = 1; m_cnt[ch] = 0; end
            else begin m_ce[ch] = 0; m_cnt[ch]++; end
        end
        case (old_ph)
            PH_RST:  if (rem == 1) begin ph = PH_WAIT; rem = LOCK_TIMEOUT; end else rem--;
            PH_WAIT: if (ls) begin ph = PH_STB; rem = LOCK_STABLE_CYCLES; end
                     else if (rem == 1) ph = PH_FAIL;
                     else rem--;
            PH_STB:  if (!ls) ph = PH_FAIL; else if (rem == 1) ph = PH_RUN; else rem--;
            PH_RUN:  if (!ls) ph = PH_FAIL;
                     else if (rl) begin retries = 0; ph = PH_RST; rem = PLL_RST_CYCLES; end
            PH_FAIL: begin
                retries = (retries < MAX_RETRIES) ? retries + 1 : MAX_RETRIES;
                if (retries == MAX_RETRIES) ph = PH_BYP;
                else begin ph = PH_RST; rem = PLL_RST_CYCLES; end
            end
            PH_BYP:  if (rl) begin retries = 0; ph = PH_RST; rem = PLL_RST_CYCLES; end
            default: ;
        endcase
    endfunction

    // Driver: inputs change 1 time unit after a rising edge; model advances on the edge.
    task automatic step(bit lk, bit rl, logic [15:0] dv);
        pll_lock   = lk;
        relock_req = rl;
        ce_div     = dv;
        @(posedge clk);
        if (!RESET) model_reset();
        else model_edge(lk, rl, dv);
        exp_q.push_back(model_out());
        #1;
        relock_req = 1'b0;
    endtask

    task automatic tick(int n);
        for (int i = 0; i < n; i++) step(cur_lock, 1'b0, cur_div);
    endtask

    task automatic run_until(int p, int cap, string name);
        int n;
        n = 0;
        while (ph != p && n < cap) begin
            step(cur_lock, (ph == PH_BYP) && (p != PH_BYP), cur_div);
            n++;
        end
        if (ph != p) begin
            total++; bad++;
            $display("FAIL %s: timed out after %0d cycles, phase=%0d required=%0d", name, n, ph, p);
        end
    endtask

    task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare against the next expectation.
    always @(negedge clk) begin
        logic [8:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pll_resetb, pll_bypass, sys_reset_n, locked, fault, retry_count, ce};
            total++;
            if (a !== e) begin
                bad++;
                if (bad <= 20)
                    $display("FAIL outputs t=%0t phase=%0d actual=%b required=%b", $time, ph, a, e);
            end
        end
    end

    initial begin
        RESET = 1'b0; pll_lock = 1'b0; relock_req = 1'b0;
        cur_lock = 1'b0;
        cur_div = {8'd5, 8'd1};
        ce_div  = cur_div;
        model_reset();
        tick(3);
        chk("reset_values", {pll_resetb, pll_bypass, sys_reset_n, locked, fault, retry_count, ce}, 9'd0);

        // Normal lock: lock appears at cycle 40 after release.
        RESET = 1'b1;
        tick(40);
        cur_lock = 1'b1;
        run_until(PH_RUN, 200, "normal_lock");
        tick(30);
        chk("run_status", {6'd0, locked, sys_reset_n, retry_count == 2'd0}, 9'b111);

        // Divisor change while ch1 counter sits at 4, then zero divisors.
        for (int i = 0; i < 10 && m_cnt[1] != 4; i++) tick(1);
        cur_div[15:8] = 8'd3; tick(10);
        cur_div[15:8] = 8'd0; tick(6);
        cur_div[7:0]  = 8'd0; cur_div[15:8] = 8'd4; tick(10);
        for (int i = 0; i < 5; i++) begin
            cur_div = 16'($urandom_range(0, 16'hffff)) & 16'h0f0f;
            tick($urandom_range(5, 30));
        end

        // Lock loss coinciding with relock_req in RUN.
        cur_lock = 1'b0;
        step(1'b0, 1'b0, cur_div);
        step(1'b0, 1'b0, cur_div);
        step(1'b0, 1'b1, cur_div);
        cur_lock = 1'b1;
        tick(2);
        chk("loss_beats_relock", {7'd0, retry_count}, 9'd1);
        run_until(PH_RUN, 300, "relock_after_loss");
        tick(5);

        // Relock clears retries; then a one-cycle flap during STABLE.
        step(1'b1, 1'b1, cur_div);
        run_until(PH_STB, 100, "reach_stable");
        tick($urandom_range(10, 40));
        step(1'b0, 1'b0, cur_div);
        run_until(PH_RUN, 400, "relock_after_flap");
        tick(3);
        chk("flap_retry", {7'd0, retry_count}, 9'd1);

        // Persistent timeout leads to bypass; lock is ignored there.
        cur_lock = 1'b0;
        step(1'b0, 1'b1, cur_div);
        run_until(PH_BYP, 3500, "reach_bypass");
        tick(3);
        chk("bypass", {3'd0, pll_bypass, fault, sys_reset_n, locked, retry_count}, 9'b111011);
        for (int i = 0; i < 20; i++) step(bit'($urandom_range(0, 1)), 1'b0, cur_div);
        cur_lock = 1'b1;
        tick(3);
        step(1'b1, 1'b1, cur_div);
        run_until(PH_RUN, 300, "recover_from_bypass");

        // Random soak.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) cur_lock = ~cur_lock;
            if ($urandom_range(0, 49) == 0) cur_div = 16'($urandom_range(0, 16'hffff)) & 16'h0707;
            step(cur_lock, $urandom_range(0, 99) == 0, cur_div);
        end

        // Asynchronous reset mid-RUN.
        cur_lock = 1'b1;
        run_until(PH_RUN, 5000, "run_before_async_reset");
        tick(10);
        #2;
        RESET = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset", {pll_resetb, pll_bypass, sys_reset_n, locked, fault, retry_count, ce}, 9'd0);
        model_reset();
        tick(4);
        RESET = 1'b1;
        run_until(PH_RUN, 300, "run_after_async_reset");
        tick(20);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
